vc_drain_arb: RTL
=================

VC_DRAIN_ARB -- requirements
Module: vc_drain_arb

Interface
REQ-001 VCN, 4, number of virtual channels; power of 2, at least 2.
REQ-002 D, 11, payload width per VC.
REQ-003 CREDITS, 4, downstream buffer slots per VC; counter width CW = $clog2(CREDITS+1).
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 en  in  1  arbitration enable; 0 blocks new grants, and a held output still drains.
REQ-007 empty_n  in  VCN  per-VC not-empty flags from the linked-list FIFO.
REQ-008 q  in  VCN*D  show-ahead head data per VC from the FIFO; VC v occupies bits [v*D +: D].
REQ-009 re  out  1  FIFO read strobe, combinational.
REQ-010 r_vc  out  $clog2(VCN)  VC being read, combinational; value is don't-care when re=0.
REQ-011 out_valid  out  1  registered output beat valid.
REQ-012 out_ready  in  1  downstream accept.
REQ-013 out_vc  out  $clog2(VCN)  registered VC tag of the output beat.
REQ-014 out_data  out  D  registered payload.
REQ-015 credit_ret  in  VCN  one-cycle pulse per VC; each pulse returns one downstream slot.
REQ-016 credit_err  out  1  sticky flag; set when a credit return would overflow a counter.

Function
REQ-017 Eligibility: VC v is eligible when empty_n[v]=1 and credit[v]>0.
REQ-018 Slot free: slot_free = ~out_valid | out_ready.
REQ-019 Grant: the block issues a grant when en=1, slot_free=1 and at least one VC is eligible.
REQ-020 Round-robin order: the winner is the first eligible VC found searching upward from rr_ptr+1, wrapping modulo VCN.
REQ-021 Pointer update: on a grant, rr_ptr takes the winner's value; rr_ptr is unchanged when there is no grant.
REQ-022 FIFO read: re = grant; r_vc = winner.
REQ-023 Invalid reads: re is never asserted for a VC with empty_n=0.
REQ-024 Output load: on a grant, at the next edge out_valid<=1, out_vc<=winner, out_data<=q[winner*D +: D].
REQ-025 Latency: a beat appears at the output exactly 1 cycle after re.
REQ-026 Output clear: when out_valid=1, out_ready=1 and there is no grant, out_valid<=0 at the next edge.
REQ-027 Output hold: out_data and out_vc hold their values while out_valid=1 and out_ready=0.
REQ-028 Output when idle: out_data and out_vc hold their last value when out_valid=0.
REQ-029 Back-to-back: a beat accepted with out_ready=1 and a new grant in the same cycle give continuous out_valid=1 with the new beat loaded.
REQ-030 Credit decrement: on a grant, credit[winner] decrements by 1.
REQ-031 Credit increment: a credit_ret[v] pulse increments credit[v] by 1.
REQ-032 Simultaneous credit events: a grant to VC v and credit_ret[v] in the same cycle leave credit[v] unchanged.
REQ-033 Credit overflow: credit_ret[v] with credit[v]=CREDITS and no grant to v leaves credit[v]=CREDITS and sets credit_err=1.
REQ-034 Credit width: counters never wrap below 0; credit=0 makes the VC ineligible.
REQ-035 Multiple returns: credit_ret pulses on several VCs in the same cycle are all honoured independently.

Reset
REQ-036 Asynchronous reset values: while rst=1, out_valid=0, out_vc=0, out_data=0, credit_err=0, every credit[v]=CREDITS, rr_ptr=VCN-1 (first search starts at VC0).
REQ-037 Outputs in reset: re=0 while rst=1, regardless of the other inputs.
REQ-038 Reset mid-operation: asserting rst discards any held output beat and does not issue a read; credit_err clears only on reset.

Verification
REQ-039 Reset, then empty_n=4'b1111, out_ready=1, en=1 -> r_vc sequence 0,1,2,3,0 on consecutive cycles; out_vc follows one cycle later; out_valid stays 1.
REQ-040 Only VC2 non-empty, no credit_ret -> exactly 4 grants to VC2, then re=0 with credit[2]=0; one credit_ret[2] pulse -> exactly one further grant.
REQ-041 out_ready=0 while out_valid=1 -> re=0 and out_data/out_vc stable for 5 cycles; out_ready=1 -> the held beat is accepted and a new grant occurs in the same cycle.
REQ-042 Grant to VC1 with credit[1]=2 and credit_ret[1] in the same cycle -> credit[1] stays 2; credit_ret[0] with credit[0]=4 -> credit[0] stays 4 and credit_err=1 until rst.
REQ-043 rst asserted asynchronously between edges with out_valid=1 -> out_valid=0 and re=0 immediately; after release, the first grant goes to the lowest-numbered eligible VC.
REQ-044 Connected to the linked-list FIFO with random write/credit traffic -> per-VC payload order preserved, no read of an empty VC, and granted-minus-returned per VC never exceeds CREDITS.

Source files
------------

// File: rtl/vc_drain_arb.sv
// Round-robin drain arbiter. It moves show-ahead FIFO heads from VCN virtual
// channels onto one registered output, and it keeps a per-VC credit count for the downstream buffer.
module vc_drain_arb #(
  parameter  int VCN     = 4,
  parameter  int D       = 11,
  parameter  int CREDITS = 4,
  localparam int VW      = $clog2(VCN),
  localparam int CW      = $clog2(CREDITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [VCN-1:0]   empty_n,
  input  logic [VCN*D-1:0] q,
  output logic             re,
  output logic [VW-1:0]    r_vc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [VW-1:0]    out_vc,
  output logic [D-1:0]     out_data,
  input  logic [VCN-1:0]   credit_ret,
  output logic             credit_err
);

  logic [VW-1:0]  r_rr_ptr;
  logic [CW-1:0]  r_credit [VCN];
  logic           r_credit_err;
  logic           r_out_valid;
  logic [VW-1:0]  r_out_vc;
  logic [D-1:0]   r_out_data;

  logic [VCN-1:0] w_elig;
  logic [VCN-1:0] w_dec;
  logic           w_found;
  logic           w_grant;
  logic [VW-1:0]  w_winner;
  logic [VW-1:0]  w_idx;

  // NOTE: every variable assigned here gets a default first, so no latch is inferred.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int v = 0; v < VCN; v++) begin
      w_elig[v] = empty_n[v] && (r_credit[v] != '0);
    end
    // The search starts one past the last winner. At offset VCN it wraps back to the last winner.
    for (int i = 1; i <= VCN; i++) begin
      w_idx = r_rr_ptr + VW'(i);
      if (!w_found && w_elig[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  // rst gates the grant directly, so no read strobe reaches the FIFO while reset is held.
  assign w_grant = en && (!r_out_valid || out_ready) && w_found && !rst;

  always_comb begin
    for (int v = 0; v < VCN; v++) begin
      w_dec[v] = w_grant && (w_winner == VW'(v));
    end
  end

  assign re         = w_grant;
  assign r_vc       = w_winner;
  assign out_valid  = r_out_valid;
  assign out_vc     = r_out_vc;
  assign out_data   = r_out_data;
  assign credit_err = r_credit_err;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr    <= VW'(VCN - 1);
      r_out_valid <= 1'b0;
      r_out_vc    <= '0;
      r_out_data  <= '0;
    end else if (w_grant) begin
      r_rr_ptr    <= w_winner;
      r_out_valid <= 1'b1;
      r_out_vc    <= w_winner;
      r_out_data  <= q[int'(w_winner)*D +: D];
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // NOTE: the credit array is small state that has a defined reset value, so it is reset in a loop (not left as memory).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < VCN; v++) r_credit[v] <= CW'(CREDITS);
      r_credit_err <= 1'b0;
    end else begin
      for (int v = 0; v < VCN; v++) begin
        case ({credit_ret[v], w_dec[v]})
          2'b10: begin
            if (r_credit[v] == CW'(CREDITS)) r_credit_err <= 1'b1;
            else                             r_credit[v]  <= r_credit[v] + CW'(1);
          end
          2'b01:   r_credit[v] <= r_credit[v] - CW'(1);
          default: ;
        endcase
      end
    end
  end

endmodule
